// File: rtl/buffer_salidas_l1_pkg.sv
// rtl/buffer_salidas_l1_pkg.sv - shared widths, lane count and pointer-width helper
package buffer_salidas_l1_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int NUM_LANES  = 4;

    // Elaboration-time ceil(log2(value)); DEPTH is a power of two so this is exact.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/buffer_salidas_l1_if.sv
// rtl/buffer_salidas_l1_if.sv - lane push/pop and status bundle of the L1 output buffer
interface buffer_salidas_l1_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Entrada0, Entrada1, Entrada2, Entrada3;
    logic              validEntrada0, validEntrada1, validEntrada2, validEntrada3;
    logic              pop0, pop1, pop2, pop3;
    logic [DATA_W-1:0] Salida0, Salida1, Salida2, Salida3;
    logic              validSalida0, validSalida1, validSalida2, validSalida3;
    logic [3:0]        empty;
    logic [3:0]        full;
    logic [3:0]        almost_full;
    logic [3:0]        overflow;

    modport master (
        output Entrada0, Entrada1, Entrada2, Entrada3,
        output validEntrada0, validEntrada1, validEntrada2, validEntrada3,
        output pop0, pop1, pop2, pop3,
        input  Salida0, Salida1, Salida2, Salida3,
        input  validSalida0, validSalida1, validSalida2, validSalida3,
        input  empty, full, almost_full, overflow
    );

    modport slave (
        input  Entrada0, Entrada1, Entrada2, Entrada3,
        input  validEntrada0, validEntrada1, validEntrada2, validEntrada3,
        input  pop0, pop1, pop2, pop3,
        output Salida0, Salida1, Salida2, Salida3,
        output validSalida0, validSalida1, validSalida2, validSalida3,
        output empty, full, almost_full, overflow
    );
endinterface

// File: rtl/buffer_salidas_l1_fifo_carril.sv
// rtl/buffer_salidas_l1_fifo_carril.sv - single-lane FIFO with registered read, flags and sticky overflow
module fifo_carril
    import buffer_salidas_l1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              overflow
);
    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              push_ok;
    logic              pop_ok;

    // A pop in the same cycle frees the slot a push into a full lane needs.
    assign pop_ok  = pop & ~empty;
    assign push_ok = din_valid & (~full | pop_ok);

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            dout_valid  <= pop_ok;
            count       <= count_nxt;
            empty       <= (count_nxt == '0);
            full        <= (count_nxt == (AW+1)'(DEPTH));
            almost_full <= (count_nxt >= (AW+1)'(DEPTH - 1));
            if (din_valid & ~push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is not reset: pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/buffer_salidas_l1.sv
// rtl/buffer_salidas_l1.sv - four independent byte-lane FIFOs behind the level-1 1:4 demux
module buffer_salidas_l1
    import buffer_salidas_l1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    buffer_salidas_l1_if.slave bus
);
    logic [DATA_W-1:0]    din  [NUM_LANES];
    logic [DATA_W-1:0]    dout [NUM_LANES];
    logic [NUM_LANES-1:0] din_valid;
    logic [NUM_LANES-1:0] pop_req;
    logic [NUM_LANES-1:0] dout_valid;
    logic [NUM_LANES-1:0] empty_v;
    logic [NUM_LANES-1:0] full_v;
    logic [NUM_LANES-1:0] almost_full_v;
    logic [NUM_LANES-1:0] overflow_v;

    assign din[0] = bus.Entrada0;
    assign din[1] = bus.Entrada1;
    assign din[2] = bus.Entrada2;
    assign din[3] = bus.Entrada3;

    assign din_valid = {bus.validEntrada3, bus.validEntrada2, bus.validEntrada1, bus.validEntrada0};
    assign pop_req   = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fifo_carril #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         (din[g]),
            .din_valid   (din_valid[g]),
            .pop         (pop_req[g]),
            .dout        (dout[g]),
            .dout_valid  (dout_valid[g]),
            .empty       (empty_v[g]),
            .full        (full_v[g]),
            .almost_full (almost_full_v[g]),
            .overflow    (overflow_v[g])
        );
    end

    assign bus.Salida0      = dout[0];
    assign bus.Salida1      = dout[1];
    assign bus.Salida2      = dout[2];
    assign bus.Salida3      = dout[3];
    assign bus.validSalida0 = dout_valid[0];
    assign bus.validSalida1 = dout_valid[1];
    assign bus.validSalida2 = dout_valid[2];
    assign bus.validSalida3 = dout_valid[3];
    assign bus.empty        = empty_v;
    assign bus.full         = full_v;
    assign bus.almost_full  = almost_full_v;
    assign bus.overflow     = overflow_v;

endmodule
